mem_arbiter: RTL
================

# mem_arbiter

Two-port arbiter that shares one single-port synchronous word memory between the core's instruction-fetch port and its load/store data port, replacing separate instruction and data memories with a unified memory. Accepts at most one request per cycle over valid/ready handshakes, drives the memory, and routes each 1-cycle-latency read result back to the requester that issued it. Data has priority, and an anti-starvation counter guarantees forward progress for fetch.

## Interface
- `ADDR_W`, 32, byte-address width of both requester ports.
- `DATA_W`, 32, word width; `STRB_W = DATA_W/8`.
- `MAX_STREAK`, 4, consecutive data grants allowed while fetch is waiting; range 1..15.

- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  synchronous, active-high.
- `i_req_valid` / `i_req_ready`  in / out  1  fetch request handshake.
- `i_req_addr`  in  ADDR_W  fetch byte address.
- `i_resp_valid` / `i_resp_ready`  out / in  1  fetch response handshake.
- `i_resp_rdata`  out  DATA_W  fetched word.
- `d_req_valid` / `d_req_ready`  in / out  1  data request handshake.
- `d_req_addr`  in  ADDR_W  data byte address.
- `d_req_we`  in  1  1 = store, 0 = load.
- `d_req_wstrb`  in  STRB_W  store byte enables.
- `d_req_wdata`  in  DATA_W  store data.
- `d_resp_valid` / `d_resp_ready`  out / in  1  data response handshake; stores also get a response.
- `d_resp_rdata`  out  DATA_W  load data; 0 for store responses.
- `mem_en`  out  1  memory access this cycle.
- `mem_we`  out  STRB_W  byte write enables; all 0 for reads.
- `mem_addr`  out  ADDR_W-2  word index, equal to `addr[ADDR_W-1:2]`; `addr[1:0]` is ignored.
- `mem_wdata`  out  DATA_W  write data.
- `mem_rdata`  in  DATA_W  read data, valid the cycle after `mem_en`.

## Operation
- **Eligibility.** A port is eligible iff both of these hold:
  - its hold register is empty;
  - it does not have an in-flight response this cycle while its `resp_ready` is 0.
- **Grant.**
  - If only one eligible port has valid asserted, that port wins.
  - If both eligible ports have valid asserted, data wins unless `streak == MAX_STREAK`, in which case fetch wins.
  - `x_req_ready` is 1 only for the winning port. The handshake completes in the same cycle.
- **Streak counter.**
  - Increments when data wins while fetch is valid and eligible.
  - Clears to 0 on any fetch grant, or on any cycle where fetch is not valid.
  - Saturates at `MAX_STREAK`.
- **Memory drive.**
  - On a grant: `mem_en=1`, and `mem_addr`/`mem_wdata` come from the winner.
  - `mem_we = d_req_wstrb` for a data store, otherwise 0.
  - With no grant, `mem_en=0` and `mem_we=0`.
- **In-flight tracking.** A registered owner field (NONE/INSTR/DATA) plus an is-store flag record the request granted in the previous cycle.
- **Response, bypass path.**
  - In the cycle after a grant, the owner's `resp_valid=1` and `rdata` is `mem_rdata` (0 for a store).
  - If the owner's `resp_ready=1`, the response completes.
  - Otherwise the data is captured into that port's hold register.
- **Response, held path.** While a hold register is full, `resp_valid=1` and `rdata` comes from the hold register. The hold register empties on `resp_ready=1`.
- **Ordering.** Each port receives its responses in request order and has at most one outstanding response, whether in flight or held.

## Timing
- **Reset values:** all `req_ready`=0, all `resp_valid`=0, `resp_rdata`=0, `mem_en`=0, `mem_we`=0, owner=NONE, holds empty, streak=0.
- **Latency:** request accepted in cycle t → response at t+1 when not stalled.
- **Throughput:** one grant per cycle. Back-to-back grants to the same port are allowed when its `resp_ready` stays 1.
- **Combinational paths:**
  - `req_ready` depends combinationally on `req_valid`, streak, hold state, owner and `resp_ready`.
  - `mem_*` outputs are combinational from the winning request.
  - There is no path from `mem_rdata` to `req_ready`.
- **Reset mid-operation:** reset asserted in any cycle drops the in-flight response and the hold contents. The next cycle shows reset values, and the memory write of that cycle is suppressed (`mem_en=0`).
- **Simultaneous events:** a hold register draining in cycle t does not make its port eligible until t+1.

## Structure
- **Package `mem_bus_pkg`:**
  - `owner_t` enum {OWN_NONE, OWN_INSTR, OWN_DATA};
  - `STRB_W`;
  - streak counter width constant (4 bits).
- **Sub-module `resp_hold`:** a one-entry skid register (valid + data, bypass mux). It is instantiated once per port.
- **Arbitration logic, streak counter and owner register** stay in `mem_arbiter`.

## Test plan
- **Fetch only:** `i_req` to 0x0, 0x4, 0x8 on consecutive cycles with `i_resp_ready=1` → `mem_addr` 0,1,2; `i_resp_rdata` equals memory words 0,1,2 at t+1, t+2, t+3.
- **Store then load:**
  - store wstrb=0b0011, wdata=0xDEADBEEF to 0x10 (word initially 0x11223344) → `d_resp_valid` with rdata 0;
  - following load of 0x10 → 0x1122BEEF.
- **Contention and starvation:** both ports valid continuously, MAX_STREAK=4 → grant pattern D,D,D,D,I repeating; a fetch grant occurs within 5 cycles.
- **Backpressure:**
  - `d_resp_ready=0` for 3 cycles after a load → `d_resp_valid` held with stable data;
  - no data grant until the cycle after the response is accepted;
  - fetch continues to be granted meanwhile.
- **Reset mid-flight:** reset asserted the cycle after a fetch grant → no `i_resp_valid` in the following cycle; all outputs at reset values.
- **Misaligned address:** `i_req_addr`=0x7 → `mem_addr`=1.

Source files
------------

// File: rtl/mem_bus_pkg.sv
// mem_bus_pkg: shared types and constants for the unified instruction/data memory arbiter.
package mem_bus_pkg;
    localparam int STRB_W = 4;
    localparam int STREAK_W = 4;
    typedef enum logic [1:0] {OWN_NONE, OWN_INSTR, OWN_DATA} owner_t;
endpackage

// File: rtl/mem_arbiter_resp_hold.sv
// resp_hold: one-entry skid register that presents a read result directly or from a hold slot.
module resp_hold #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              full
);
    logic              full_q, full_d;
    logic [DATA_W-1:0] data_q, data_d;
    always_comb begin
        full_d = full_q ? !out_ready : in_valid && !out_ready;
        data_d = full_q ? data_q : in_data;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            full_q <= 1'b0;
            data_q <= '0;
        end else begin
            full_q <= full_d;
            data_q <= data_d;
        end
    end
    // Reset hides a response that would otherwise be bypassed during the reset cycle.
    assign full      = full_q;
    assign out_valid = !reset && (full_q || in_valid);
    assign out_data  = out_valid ? (full_q ? data_q : in_data) : '0;
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port word memory between fetch and load/store ports, data first with fetch anti-starvation.
module mem_arbiter
    import mem_bus_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MAX_STREAK = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                i_req_valid,
    output logic                i_req_ready,
    input  logic [ADDR_W-1:0]   i_req_addr,
    output logic                i_resp_valid,
    input  logic                i_resp_ready,
    output logic [DATA_W-1:0]   i_resp_rdata,
    input  logic                d_req_valid,
    output logic                d_req_ready,
    input  logic [ADDR_W-1:0]   d_req_addr,
    input  logic                d_req_we,
    input  logic [DATA_W/8-1:0] d_req_wstrb,
    input  logic [DATA_W-1:0]   d_req_wdata,
    output logic                d_resp_valid,
    input  logic                d_resp_ready,
    output logic [DATA_W-1:0]   d_resp_rdata,
    output logic                mem_en,
    output logic [DATA_W/8-1:0] mem_we,
    output logic [ADDR_W-3:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic [DATA_W-1:0]   mem_rdata
);
    owner_t              owner_q, owner_d;
    logic                store_q, store_d;
    logic [STREAK_W-1:0] streak_q, streak_d;
    logic                i_full, d_full, i_fly, d_fly;
    logic                i_elig, d_elig, i_win, d_win, at_max;
    assign i_fly  = owner_q == OWN_INSTR;
    assign d_fly  = owner_q == OWN_DATA;
    assign at_max = streak_q == STREAK_W'(MAX_STREAK);
    always_comb begin
        i_elig   = !i_full && !(i_fly && !i_resp_ready);
        d_elig   = !d_full && !(d_fly && !d_resp_ready);
        i_win    = !reset && i_elig && i_req_valid && !(d_elig && d_req_valid && !at_max);
        d_win    = !reset && d_elig && d_req_valid && !i_win;
        owner_d  = i_win ? OWN_INSTR : d_win ? OWN_DATA : OWN_NONE;
        store_d  = d_win && d_req_we;
        // Only data wins that actually overtake a ready fetch count towards starvation.
        streak_d = (!i_req_valid || i_win) ? '0
                 : (d_win && i_elig && !at_max) ? streak_q + 1'b1 : streak_q;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            owner_q  <= OWN_NONE;
            store_q  <= 1'b0;
            streak_q <= '0;
        end else begin
            owner_q  <= owner_d;
            store_q  <= store_d;
            streak_q <= streak_d;
        end
    end
    assign i_req_ready = i_win;
    assign d_req_ready = d_win;
    assign mem_en      = i_win || d_win;
    assign mem_we      = store_d ? d_req_wstrb : '0;
    assign mem_addr    = d_win ? d_req_addr[ADDR_W-1:2] : i_req_addr[ADDR_W-1:2];
    assign mem_wdata   = d_win ? d_req_wdata : '0;
    resp_hold #(.DATA_W(DATA_W)) u_i_hold (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (i_fly),
        .in_data   (mem_rdata),
        .out_ready (i_resp_ready),
        .out_valid (i_resp_valid),
        .out_data  (i_resp_rdata),
        .full      (i_full)
    );
    resp_hold #(.DATA_W(DATA_W)) u_d_hold (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (d_fly),
        .in_data   (store_q ? '0 : mem_rdata),
        .out_ready (d_resp_ready),
        .out_valid (d_resp_valid),
        .out_data  (d_resp_rdata),
        .full      (d_full)
    );
endmodule
